gaussian_blur_dma: RTL

Stream master for the Gaussian_Blur accelerator. On a start pulse it reads `i_num_pix` 24-bit RGB pixels from a source SRAM and pushes them into the blur's rgb input channel. It collects the same number of 32-bit results from the blur's result channel and writes them to a destination SRAM. It owns the far end of both busy/vld channels: it is the producer of `rgb` and the consumer of `result`.

---
 rtl/gaussian_blur_dma_pkg.sv | 16 +
 rtl/gaussian_blur_dma_fifo.sv | 57 +++++
 rtl/gaussian_blur_dma.sv | 138 +++++++++++++
 3 files changed

// File: rtl/gaussian_blur_dma_pkg.sv
// Shared types and widths for the Gaussian_Blur stream master.
// Pixels travel as {sof, R, G, B}; results are full 32-bit words.
package gaussian_blur_dma_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int RGB_W        = 24;
  localparam int RGB_FLAG_BIT = 24;
  localparam int PIX_W        = RGB_W + 1;
  localparam int RESULT_W     = 32;

endpackage

// File: rtl/gaussian_blur_dma_fifo.sv
// Pixel prefetch FIFO between the source SRAM and the blur rgb channel.
// A pop on full frees the slot the same-cycle push lands in.
module blur_pix_fifo #(
  parameter int D = 4,
  parameter int W = 25
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic [W-1:0]           i_push_data,
  input  logic                   i_pop,
  output logic [W-1:0]           o_head,
  output logic [$clog2(D):0]     o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(D);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [D];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    do_pop  = i_pop & ~o_empty;
    do_push = i_push & (~o_full | do_pop);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push)
      mem[wr_ptr] <= i_push_data;
  end

  assign o_head  = mem[rd_ptr];
  assign o_count = count;
  assign o_full  = (count == CW'(D));
  assign o_empty = (count == '0);

endmodule

// File: rtl/gaussian_blur_dma.sv
// Stream master: source SRAM -> blur rgb channel, blur result
// channel -> destination SRAM, one job per start pulse.
module gaussian_blur_dma
  import gaussian_blur_dma_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int FIFO_D = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [ADDR_W-1:0]   i_src_base,
  input  logic [ADDR_W-1:0]   i_dst_base,
  input  logic [ADDR_W-1:0]   i_num_pix,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_rd_en,
  output logic [ADDR_W-1:0]   o_rd_addr,
  input  logic [RGB_W-1:0]    i_rd_data,
  output logic                o_wr_en,
  output logic [ADDR_W-1:0]   o_wr_addr,
  output logic [RESULT_W-1:0] o_wr_data,
  output logic                o_rgb_vld,
  output logic [PIX_W-1:0]    o_rgb_data,
  input  logic                i_rgb_busy,
  input  logic                i_result_vld,
  input  logic [RESULT_W-1:0] i_result_data,
  output logic                o_result_busy
);

  localparam int CW = $clog2(FIFO_D) + 1;
  localparam logic [CW:0] OCC_MAX = (CW+1)'(FIFO_D);

  state_t            state;
  logic [ADDR_W-1:0] src_base;
  logic [ADDR_W-1:0] dst_base;
  logic [ADDR_W-1:0] num_pix;
  logic [ADDR_W-1:0] rd_cnt;
  logic [ADDR_W-1:0] wr_cnt;
  logic              inflight;
  logic              inflight_sof;

  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [PIX_W-1:0]  fifo_head;
  logic              fifo_flush;

  logic              start_ok;
  logic              rgb_xfer;
  logic              res_xfer;
  logic              rd_issue;
  logic              last_wr;
  logic [CW:0]       occ;

  always_comb begin
    start_ok = (state == S_IDLE) & i_start;
    rgb_xfer = ~fifo_empty & ~i_rgb_busy;
    res_xfer = (state == S_RUN) & i_result_vld;
    // occupancy counts pixels already requested but not yet pushed
    occ      = {1'b0, fifo_count}
             + (CW+1)'(inflight)
             - (CW+1)'(rgb_xfer);
    rd_issue = (state == S_RUN)
             & (rd_cnt < num_pix)
             & (occ < OCC_MAX);
    last_wr  = res_xfer
             & ((wr_cnt + ADDR_W'(1)) == num_pix);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      src_base     <= '0;
      dst_base     <= '0;
      num_pix      <= '0;
      rd_cnt       <= '0;
      wr_cnt       <= '0;
      inflight     <= 1'b0;
      inflight_sof <= 1'b0;
    end else begin
      inflight     <= rd_issue;
      inflight_sof <= rd_issue & (rd_cnt == '0);
      unique case (state)
        S_IDLE: begin
          if (i_start) begin
            src_base <= i_src_base;
            dst_base <= i_dst_base;
            num_pix  <= i_num_pix;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            state    <= (i_num_pix == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (rd_issue)
            rd_cnt <= rd_cnt + ADDR_W'(1);
          if (res_xfer)
            wr_cnt <= wr_cnt + ADDR_W'(1);
          if (last_wr)
            state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // a new job never inherits pixels left over from an aborted one
  assign fifo_flush = i_rst | start_ok;

  blur_pix_fifo #(
    .D (FIFO_D),
    .W (PIX_W)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (fifo_flush),
    .i_push      (inflight),
    .i_push_data ({inflight_sof, i_rd_data}),
    .i_pop       (rgb_xfer),
    .o_head      (fifo_head),
    .o_count     (fifo_count),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty)
  );

  assign o_busy        = (state == S_RUN);
  assign o_done        = (state == S_DONE);
  assign o_rd_en       = rd_issue;
  assign o_rd_addr     = rd_issue ? src_base + rd_cnt : '0;
  assign o_wr_en       = res_xfer;
  assign o_wr_addr     = res_xfer ? dst_base + wr_cnt : '0;
  assign o_wr_data     = res_xfer ? i_result_data : '0;
  assign o_rgb_vld     = ~fifo_empty;
  assign o_rgb_data    = fifo_empty ? '0 : fifo_head;
  assign o_result_busy = (state != S_RUN);

endmodule
